// File: rtl/tt_div_pkg.sv
// Shared definitions for the sequential divider tile: FSM states, uio pin
// indices and the quotient reported on divide-by-zero.
package tt_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int START_BIT = 0;
  localparam int BUSY_BIT  = 1;
  localparam int DONE_BIT  = 2;
  localparam int ERR_BIT   = 3;

  localparam logic [7:0] UIO_OE_MASK = 8'h0E;
  localparam logic [3:0] DIV0_QUOT   = '1;

endpackage

// File: rtl/tt_um_seq_div_bla_sub.sv
// Combinational borrow-lookahead subtractor, diff = x - y; the borrow chain
// uses the same generate/propagate structure as the lookahead adder tile.
module bla_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   b;

  assign b[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      // Bit generates a borrow when x=0,y=1; propagates one when x==y.
      assign g[gi]    = ~x[gi] & y[gi];
      assign p[gi]    = ~(x[gi] ^ y[gi]);
      assign b[gi+1]  = g[gi] | (p[gi] & b[gi]);
      assign diff[gi] = x[gi] ^ y[gi] ^ b[gi];
    end
  endgenerate

  assign borrow_out = b[W];

endmodule

// File: rtl/tt_um_seq_div.sv
// Iterative unsigned restoring divider on the TinyTapeout pin map: one
// quotient bit per clock, results latched into output registers on completion.
module tt_um_seq_div
  import tt_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  assign a_in = ui_in[WIDTH-1:0];
  assign b_in = ui_in[4 +: WIDTH];

  state_t           state_reg;
  logic             start_q;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH:0]   rem_reg;
  logic [2:0]       cnt_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;

  logic             start_acc;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH:0]   quo_ext;
  logic [WIDTH-1:0] quo_next;
  logic             last_iter;

  assign start_acc = uio_in[START_BIT] & ~start_q & (state_reg != RUN);

  assign rem_shift = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};

  bla_sub #(.W(WIDTH + 1)) u_sub (
    .x          (rem_shift),
    .y          ({1'b0, dvs_reg}),
    .diff       (trial),
    .borrow_out (borrow)
  );

  // Restore on borrow: the trial difference is simply discarded.
  assign rem_next  = borrow ? rem_shift : trial;
  assign quo_ext   = {quo_reg, ~borrow};
  assign quo_next  = quo_ext[WIDTH-1:0];
  assign last_iter = (cnt_reg == 3'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      start_q   <= 1'b0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      start_q <= uio_in[START_BIT];
      case (state_reg)
        RUN: begin
          dvd_reg <= dvd_reg << 1;
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + 3'd1;
          if (last_iter) begin
            q_reg     <= quo_next;
            r_reg     <= rem_next[WIDTH-1:0];
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          if (start_acc) begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (b_in == '0) begin
              q_reg     <= DIV0_QUOT[WIDTH-1:0];
              r_reg     <= a_in;
              err_reg   <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              dvd_reg   <= a_in;
              dvs_reg   <= b_in;
              quo_reg   <= '0;
              rem_reg   <= '0;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end
          end
        end
      endcase
    end
  end

  assign uo_out = {4'(r_reg), 4'(q_reg)};
  assign uio_oe = UIO_OE_MASK;

  always_comb begin
    uio_out           = '0;
    uio_out[BUSY_BIT] = busy_reg;
    uio_out[DONE_BIT] = done_reg;
    uio_out[ERR_BIT]  = err_reg;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_seq_div.sv
// Randomised and directed bench for tt_um_seq_div against an arithmetic
// reference (A/B, A%B, divide-by-zero rule) with latency and handshake checks.
module tb_tt_um_seq_div;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_asserts = 0;
  int n_fail    = 0;

  tt_um_seq_div dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop start for one cycle, present operands, raise start and step through
  // the accepting edge.
  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    uio_in[0] = 1'b0;
    tick();
    ui_in     = {b, a};
    uio_in[0] = 1'b1;
    tick();
  endtask

  // Called just after the accepting edge; follows the operation to done,
  // checking latency, busy length, output hold and the final result.
  task automatic finish_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] prev_out, input bit full);
    int lat   = 0;
    int busyc = 0;
    logic [3:0] eq;
    logic [3:0] er;
    bit held = 1'b1;
    if (b == 0) begin
      eq = 4'hF;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    while (uio_out[2] !== 1'b1 && lat < 12) begin
      if (uio_out[1] === 1'b1) busyc++;
      if (uo_out !== prev_out) held = 1'b0;
      tick();
      lat++;
    end
    check({tag, " quot"}, uo_out[3:0], eq);
    check({tag, " rem"},  uo_out[7:4], er);
    if (full) begin
      check({tag, " latency"}, lat, (b == 0) ? 0 : 4);
      check({tag, " busy_cycles"}, busyc, (b == 0) ? 0 : 4);
      check({tag, " err"}, uio_out[3], (b == 0));
      check({tag, " busy_end"}, uio_out[1], 1'b0);
      check({tag, " out_held"}, held, 1'b1);
    end
  endtask

  initial begin
    logic [7:0] prev;
    logic [3:0] ra;
    logic [3:0] rb;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tick();
    tick();
    check("reset uo_out", uo_out, 8'h00);
    check("reset uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h0E);
    rst_n = 1'b1;
    tick();

    // 13/3 with a start pulse
    launch(4'd13, 4'd3);
    uio_in[0] = 1'b0;
    check("13/3 busy_at_accept", uio_out[1], 1'b1);
    finish_op("13/3", 4'd13, 4'd3, 8'h00, 1'b1);
    check("13/3 uio_out", uio_out, 8'h04);

    // 15/1, then 3/7 started from DONE
    launch(4'd15, 4'd1);
    finish_op("15/1", 4'd15, 4'd1, {4'd1, 4'd4}, 1'b1);
    launch(4'd3, 4'd7);
    check("3/7 done_dropped", uio_out[2], 1'b0);
    finish_op("3/7", 4'd3, 4'd7, {4'd0, 4'd15}, 1'b1);

    // start held high after completion must not retrigger
    for (int i = 0; i < 6; i++) tick();
    check("held start done", uio_out[2], 1'b1);
    check("held start busy", uio_out[1], 1'b0);

    // divide by zero
    launch(4'd9, 4'd0);
    finish_op("9/0", 4'd9, 4'd0, {4'd3, 4'd0}, 1'b1);
    check("9/0 uio_out", uio_out, 8'h0C);

    // second start during RUN is ignored, operands stay latched
    launch(4'd13, 4'd3);
    uio_in[0] = 1'b0;
    tick();
    ui_in     = {4'd1, 4'd2};
    uio_in[0] = 1'b1;
    finish_op("ignored start", 4'd13, 4'd3, 8'h00, 1'b0);
    check("ignored start busy", uio_out[1], 1'b0);

    // reset in the third RUN cycle aborts
    launch(4'd14, 4'd5);
    uio_in[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort uo_out", uo_out, 8'h00);
    check("abort uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    launch(4'd14, 4'd5);
    finish_op("after abort", 4'd14, 4'd5, 8'h00, 1'b1);

    // exhaustive sweep, start held high between operations
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        prev = uo_out;
        launch(4'(a), 4'(b));
        finish_op($sformatf("sweep %0d/%0d", a, b), 4'(a), 4'(b), prev, 1'b0);
      end
    end

    // randomised operands, occasional zero divisor
    for (int i = 0; i < 60; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      prev = uo_out;
      launch(ra, rb);
      finish_op($sformatf("rand %0d/%0d", ra, rb), ra, rb, prev, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
